// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES constant tables, key-schedule helpers and engine state enum
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Table entries use DES numbering: entry n names source bit n, bit 1 = MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Encrypt left-rotation amount for rounds 1..16
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Each S-box packed row-major (row*16+col), entry 0 in the top nibble
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [56:1] pc1_perm(input logic [64:1] k);
    logic [56:1] o;
    o = '0;
    for (int i = 0; i < 56; i++) o = {o[55:1], 1'(k >> (64 - PC1[i]))};
    return o;
  endfunction

  function automatic logic [48:1] pc2_perm(input logic [56:1] cd);
    logic [48:1] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[47:1], 1'(cd >> (56 - PC2[i]))};
    return o;
  endfunction

  function automatic logic [48:1] e_perm(input logic [32:1] r);
    logic [48:1] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[47:1], 1'(r >> (32 - E_TBL[i]))};
    return o;
  endfunction

  function automatic logic [32:1] p_perm(input logic [32:1] s);
    logic [32:1] o;
    o = '0;
    for (int i = 0; i < 32; i++) o = {o[31:1], 1'(s >> (32 - P_TBL[i]))};
    return o;
  endfunction

  // Rotation for round cnt+1; decrypt walks the encrypt schedule backwards
  function automatic logic [1:0] round_shift(input logic dec, input logic [3:0] cnt);
    logic [3:0] mirror;
    mirror = 4'd0 - cnt;
    if (!dec) return SHIFT_SCHED[cnt];
    else if (cnt == 4'd0) return 2'd0;
    else return SHIFT_SCHED[mirror];
  endfunction

  function automatic logic [28:1] rot_half(input logic [28:1] x, input logic dec,
                                           input logic [1:0] amt);
    logic [28:1] o;
    case ({dec, amt})
      3'b001:  o = {x[27:1], x[28]};
      3'b010:  o = {x[26:1], x[28:27]};
      3'b101:  o = {x[1], x[28:2]};
      3'b110:  o = {x[2:1], x[28:3]};
      default: o = x;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/des_f_func.sv
// rtl/des_f_func.sv - combinational DES f-function P(S(E(R) xor K))
module des_f_func
  import des_pkg::*;
(
  input  logic [32:1] r_i,
  input  logic [48:1] k_i,
  output logic [32:1] f_o
);

  logic [48:1] x;
  logic [5:0]  chunk;
  logic [5:0]  idx;
  logic [32:1] s_out;

  // Expand, mix key, then run eight 6->4 S-box lookups (row = outer bits)
  always_comb begin
    x     = e_perm(r_i) ^ k_i;
    s_out = '0;
    chunk = '0;
    idx   = '0;
    for (int s = 0; s < 8; s++) begin
      chunk = 6'(x >> (42 - 6 * s));
      idx   = {chunk[5], chunk[0], chunk[4:1]};
      s_out = {s_out[28:1], 4'(SBOX[s] >> (4 * (63 - int'(idx))))};
    end
  end

  assign f_o = p_perm(s_out);

endmodule

// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative 16-round DES Feistel engine, one round per cycle
module des_round_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [32:1] L0,
  input  logic [32:1] R0,
  input  logic [64:1] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] L16,
  output logic [32:1] R16
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [32:1] l_q, l_d, r_q, r_d;
  logic [28:1] c_q, c_d, d_q, d_d;
  logic        dec_q, dec_d;

  logic [1:0]  shamt;
  logic [28:1] c_rot, d_rot;
  logic [48:1] k_rnd;
  logic [32:1] f_out;

  // Round subkey: rotate C/D for this round, then compress with PC-2
  always_comb begin
    shamt = round_shift(dec_q, cnt_q);
    c_rot = rot_half(c_q, dec_q, shamt);
    d_rot = rot_half(d_q, dec_q, shamt);
    k_rnd = pc2_perm({c_rot, d_rot});
  end

  des_f_func u_f (
    .r_i (r_q),
    .k_i (k_rnd),
    .f_o (f_out)
  );

  // Next-state: accept in IDLE, one Feistel round per ROUND cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {c_d, d_d} = pc1_perm(key);
          l_d        = L0;
          r_d        = R0;
          dec_d      = decrypt;
          cnt_d      = 4'd0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_out;
        c_d = c_rot;
        d_d = d_rot;
        if (cnt_q == 4'd15) state_d = DONE;
        else cnt_d = cnt_q + 4'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All engine state; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dec_q   <= dec_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign L16       = l_q;
  assign R16       = r_q;

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - scoreboard bench for des_round_engine against a DES reference model
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        decrypt = 1'b0;
  logic [32:1] L0 = '0;
  logic [32:1] R0 = '0;
  logic [64:1] key = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:1] L16;
  logic [32:1] R16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_ready = 0;
  bit ready_force = 1;
  bit prev_ov = 0;
  int last_acc = -1;

  logic [63:0] exp_q[$];
  int          acc_q[$];

  int PC1_T[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int E_T[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int P_T[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int SH_T[$]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [255:0] SB_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  des_round_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decrypt   (decrypt),
    .L0        (L0),
    .R0        (R0),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .L16       (L16),
    .R16       (R16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Reference model: right-justified permutation, table entries count from the MSB
  function automatic logic [63:0] perm(logic [63:0] src, int w, int t[$]);
    logic [63:0] res;
    res = '0;
    foreach (t[i]) res = (res << 1) | ((src >> (w - t[i])) & 64'd1);
    return res;
  endfunction

  function automatic logic [31:0] ref_f(logic [31:0] r, logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    int ch, row, col;
    x = 48'(perm({32'd0, r}, 32, E_T)) ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      ch  = int'((x >> (42 - 6 * s)) & 48'h3F);
      row = ((ch >> 4) & 2) | (ch & 1);
      col = (ch >> 1) & 15;
      s_out = (s_out << 4) | 32'((SB_T[s] >> (4 * (63 - (row * 16 + col)))) & 256'hF);
    end
    return 32'(perm({32'd0, s_out}, 32, P_T));
  endfunction

  // Full 16-round result {L16,R16}; decrypt applies the encrypt subkeys in reverse
  function automatic logic [63:0] ref_des(logic [31:0] l0, logic [31:0] r0, logic [63:0] k, logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    cd = 56'(perm(k, 64, PC1_T));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < SH_T[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(perm({8'd0, c, d}, 56, PC2_T));
    end
    l = l0;
    r = r0;
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ ref_f(r, dec ? ks[15 - i] : ks[i]);
      l = t;
    end
    return {l, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every DONE cycle, pop on the output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!prev_ov) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 64'(cyc), 64'hFFFF_FFFF);
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd16);
      end
      if (exp_q.size() == 0) chk("unexpected_output", {L16, R16}, 64'hX);
      else chk("result", {L16, R16}, exp_q[0]);
      chk("in_ready_in_done", 64'(in_ready), 64'd0);
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    prev_ov = rst_n && out_valid;
  end

  task automatic issue(input logic [31:0] l, input logic [31:0] r, input logic [63:0] k,
                       input logic dec, input logic [63:0] exp, input bit keep, input bit gap);
    int n;
    n = 0;
    L0 = l; R0 = r; key = k; decrypt = dec; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      if (gap && last_acc >= 0) chk("accept_gap", 64'(cyc - last_acc), 64'd18);
      last_acc = cyc;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KW = 64'h0101010101010101;

  initial begin
    logic [63:0] e1;
    logic [31:0] rl, rr;
    logic [63:0] rk;
    logic        rd;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", {L16, R16}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(32'hCC00CCFF, 32'hF0AAF0AA, K1, 1'b0, {32'h43423234, 32'h0A4CD995}, 0, 0);
    wait_drain();
    issue(32'h0A4CD995, 32'h43423234, K1, 1'b1, {32'hF0AAF0AA, 32'hCC00CCFF}, 0, 0);
    wait_drain();

    // Held result under backpressure with input noise
    ready_force = 0;
    issue(32'hCC00CCFF, 32'hF0AAF0AA, K1, 1'b0, {32'h43423234, 32'h0A4CD995}, 0, 0);
    for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      L0 = $urandom;
      key = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    ready_force = 1;
    wait_drain();

    // Weak key: encrypting twice returns the plaintext halves
    e1 = ref_des(32'h01234567, 32'h89ABCDEF, KW, 1'b0);
    issue(32'h01234567, 32'h89ABCDEF, KW, 1'b0, e1, 0, 0);
    wait_drain();
    issue(e1[31:0], e1[63:32], KW, 1'b0, {32'h89ABCDEF, 32'h01234567}, 0, 0);
    wait_drain();

    // Reset during round 7 abandons the operation
    issue(32'hCC00CCFF, 32'hF0AAF0AA, K1, 1'b0, {32'h43423234, 32'h0A4CD995}, 0, 0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", {L16, R16}, 64'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(32'hCC00CCFF, 32'hF0AAF0AA, K1, 1'b0, {32'h43423234, 32'h0A4CD995}, 0, 0);
    wait_drain();

    // Back-to-back with in_valid and out_ready held high
    last_acc = -1;
    for (int i = 0; i < 4; i++) begin
      rl = $urandom; rr = $urandom; rk = {$urandom, $urandom}; rd = 1'($urandom_range(0, 1));
      issue(rl, rr, rk, rd, ref_des(rl, rr, rk, rd), 1, 1);
    end
    in_valid = 1'b0;
    wait_drain();

    // Random traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rl = $urandom; rr = $urandom; rk = {$urandom, $urandom}; rd = 1'($urandom_range(0, 1));
      issue(rl, rr, rk, rd, ref_des(rl, rr, rk, rd), 0, 0);
    end
    wait_drain();
    rand_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
